// File: rtl/learn_score_bank.sv
// learn_score_bank: registered per-user/per-song score store for learning mode.
// It commits a score on the rising edge of `finished` and computes the
// per-user average with a sequential sum-then-restoring-divide engine.
//
// Optional feature macro: RECORD_KEEP_BEST_EN. When it is defined, a commit
// keeps only an improved score and pulses new_best.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mode          `MODELRN enables commits and averaging
//   user          selected user slot
//   song_num      selected song slot
//   finished      level from learning; a rising edge commits `score`
//   score         score to commit
//   cur_record    registered record[user][song_num], write-first
//   user_avg      floor(sum of user's records / SONGS)
//   avg_valid     user_avg reflects the currently stored records
//   busy          averaging engine in SUM or DIV
//   commit        one-cycle pulse for an accepted commit
//   new_best      one-cycle pulse for an improving commit (keep-best build only)

`ifndef MODELRN
`define MODELRN 3'd2
`endif
`ifndef MODEAUTO
`define MODEAUTO 3'd1
`endif

module learn_score_bank #(
    parameter int unsigned USERS   = 4,
    parameter int unsigned SONGS   = 3,
    parameter int unsigned SCORE_W = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [2:0]                             mode,
    input  logic [((USERS > 1) ? $clog2(USERS) : 1)-1:0] user,
    input  logic [((SONGS > 1) ? $clog2(SONGS) : 1)-1:0] song_num,
    input  logic                                   finished,
    input  logic [SCORE_W-1:0]                     score,
    output logic [SCORE_W-1:0]                     cur_record,
    output logic [SCORE_W-1:0]                     user_avg,
    output logic                                   avg_valid,
    output logic                                   busy,
    output logic                                   commit,
    output logic                                   new_best
);

    localparam int unsigned UW     = (USERS > 1) ? $clog2(USERS) : 1;
    localparam int unsigned SW     = (SONGS > 1) ? $clog2(SONGS) : 1;
    localparam int unsigned SUM_W  = SCORE_W + $clog2(SONGS + 1);
    localparam int unsigned DCNT_W = $clog2(SUM_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUM  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [SCORE_W-1:0] rec [USERS][SONGS];

    logic              fin_q;
    logic [2:0]        mode_q;
    logic [UW-1:0]     user_q;
    logic [1:0]        state, state_n;
    logic [SW-1:0]     sidx, sidx_n;
    logic [DCNT_W-1:0] dcnt, dcnt_n;
    logic [SUM_W-1:0]  acc, acc_n;
    logic [SUM_W-1:0]  quo, quo_n;
    logic [SUM_W-1:0]  rem, rem_n;
    logic [SUM_W:0]    rem_sh;
    logic [UW-1:0]     lat_user, lat_user_n;
    logic [SCORE_W-1:0] user_avg_n;
    logic              avg_valid_n;
    logic              busy_n;

    logic               lrn, in_range, req, accept, better, do_write;
    logic               user_chg, enter_lrn, restart, nb_set;
    logic [SCORE_W-1:0] cur_val;

    // Guarded record read: out-of-range slots read as zero
    function automatic logic [SCORE_W-1:0] rd_rec(input logic [UW-1:0] u,
                                                   input logic [SW-1:0] s);
        if ((32'(u) < USERS) && (32'(s) < SONGS))
            return rec[u][s];
        return '0;
    endfunction

    // Commit request decode and restart triggers
    always_comb begin
        lrn       = (mode == `MODELRN);
        in_range  = (32'(user) < USERS) && (32'(song_num) < SONGS);
        cur_val   = rd_rec(user, song_num);
        req       = finished & ~fin_q & lrn;
        accept    = req & in_range;
`ifdef RECORD_KEEP_BEST_EN
        better    = (score > cur_val);
        nb_set    = accept & better;
`else
        better    = 1'b1;
        nb_set    = 1'b0;
`endif
        do_write  = accept & better;
        user_chg  = (user != user_q);
        enter_lrn = lrn & (mode_q != `MODELRN);
        restart   = lrn & (do_write | user_chg | enter_lrn);
    end

    // Averaging FSM: next state and datapath
    always_comb begin
        state_n     = state;
        sidx_n      = sidx;
        dcnt_n      = dcnt;
        acc_n       = acc;
        quo_n       = quo;
        rem_n       = rem;
        lat_user_n  = lat_user;
        user_avg_n  = user_avg;
        avg_valid_n = avg_valid;
        rem_sh      = {rem, quo[SUM_W-1]};

        if (restart) begin
            state_n     = SUM;
            sidx_n      = '0;
            acc_n       = '0;
            lat_user_n  = user;
            avg_valid_n = 1'b0;
        end else if (!lrn) begin
            // Outside learning mode a pass in flight is abandoned
            if (state != IDLE) begin
                state_n     = IDLE;
                avg_valid_n = 1'b0;
            end else if (user_chg) begin
                avg_valid_n = 1'b0;
            end
        end else begin
            case (state)
                SUM: begin
                    acc_n = acc + SUM_W'(rd_rec(lat_user, sidx));
                    if (sidx == SW'(SONGS - 1)) begin
                        state_n = DIV;
                        quo_n   = acc + SUM_W'(rd_rec(lat_user, sidx));
                        rem_n   = '0;
                        dcnt_n  = '0;
                    end else begin
                        sidx_n = sidx + SW'(1);
                    end
                end
                DIV: begin
                    // Restoring division, one quotient bit per cycle
                    quo_n = {quo[SUM_W-2:0], 1'b0};
                    if (rem_sh >= (SUM_W + 1)'(SONGS)) begin
                        rem_n    = SUM_W'(rem_sh - (SUM_W + 1)'(SONGS));
                        quo_n[0] = 1'b1;
                    end else begin
                        rem_n = SUM_W'(rem_sh);
                    end
                    dcnt_n = dcnt + DCNT_W'(1);
                    if (dcnt == DCNT_W'(SUM_W - 1))
                        state_n = DONE;
                end
                DONE: begin
                    user_avg_n  = quo[SCORE_W-1:0];
                    avg_valid_n = 1'b1;
                    state_n     = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        busy_n = (state_n == SUM) || (state_n == DIV);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sidx       <= '0;
            dcnt       <= '0;
            acc        <= '0;
            quo        <= '0;
            rem        <= '0;
            lat_user   <= '0;
            user_avg   <= '0;
            avg_valid  <= 1'b1;
            busy       <= 1'b0;
            fin_q      <= 1'b0;
            mode_q     <= 3'd0;
            user_q     <= '0;
            commit     <= 1'b0;
            new_best   <= 1'b0;
            cur_record <= '0;
        end else begin
            state      <= state_n;
            sidx       <= sidx_n;
            dcnt       <= dcnt_n;
            acc        <= acc_n;
            quo        <= quo_n;
            rem        <= rem_n;
            lat_user   <= lat_user_n;
            user_avg   <= user_avg_n;
            avg_valid  <= avg_valid_n;
            busy       <= busy_n;
            fin_q      <= finished;
            mode_q     <= mode;
            user_q     <= user;
            commit     <= accept;
            new_best   <= nb_set;
            // Write-first: show the score being stored this cycle
            cur_record <= do_write ? score : cur_val;
        end
    end

    // Record storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < int'(USERS); u++)
                for (int s = 0; s < int'(SONGS); s++)
                    rec[u][s] <= '0;
        end else if (do_write) begin
            rec[user][song_num] <= score;
        end
    end

endmodule

// File: tb/tb_learn_score_bank.sv
`ifndef MODELRN
`define MODELRN 3'd2
`endif
`ifndef MODEAUTO
`define MODEAUTO 3'd1
`endif

module tb_learn_score_bank;

    localparam int SONGS = 3;
    localparam int SUM_W = 34;
    localparam int LAT   = SONGS + SUM_W + 2;
`ifdef RECORD_KEEP_BEST_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic [1:0]  user;
    logic [1:0]  song_num;
    logic        finished;
    logic [31:0] score;
    logic [31:0] cur_record;
    logic [31:0] user_avg;
    logic        avg_valid;
    logic        busy;
    logic        commit;
    logic        new_best;

    learn_score_bank dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .user       (user),
        .song_num   (song_num),
        .finished   (finished),
        .score      (score),
        .cur_record (cur_record),
        .user_avg   (user_avg),
        .avg_valid  (avg_valid),
        .busy       (busy),
        .commit     (commit),
        .new_best   (new_best)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int comm_cnt = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    logic [31:0] exp_avg_q[$];
    bit          exp_nb_q[$];
    logic        av_prev = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a commit or a new average
    always @(negedge clk) begin
        if (rst) begin
            av_prev = avg_valid;
        end else begin
            if (commit === 1'b1) begin
                comm_cnt++;
                if (exp_nb_q.size() == 0) check("unexpected_commit", 32'(commit), 32'd0);
                else check("new_best", 32'(new_best), 32'(exp_nb_q.pop_front()));
            end else if (new_best !== 1'b0) begin
                check("stray_new_best", 32'(new_best), 32'd0);
            end
            if (avg_valid === 1'b1 && av_prev !== 1'b1) begin
                if (exp_avg_q.size() == 0) check("unexpected_avg", user_avg, 32'hFFFF_FFFF);
                else check("user_avg", user_avg, exp_avg_q.pop_front());
            end
            av_prev = avg_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_commit(input int s, input int sc, input bit nb);
        song_num = 2'(s);
        score    = 32'(sc);
        finished = 1'b1;
        exp_nb_q.push_back(nb);
        start_cyc = cyc;
        tick();
        finished = 1'b0;
        tick();
    endtask

    task automatic wait_avg(input int e);
        bit seen;
        seen = 1'b0;
        exp_avg_q.push_back(32'(e));
        for (int n = 0; n < 300 && !seen; n++) begin
            tick();
            if (avg_valid && !busy) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) check("avg_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c0;
        rst = 1'b1; mode = 3'd0; user = 2'd0; song_num = 2'd0; finished = 1'b0; score = '0;
        tick(); tick();
        // 1: reset state
        check("rst_cur_record", cur_record, 32'd0);
        check("rst_user_avg",   user_avg,   32'd0);
        check("rst_avg_valid",  32'(avg_valid), 32'd1);
        check("rst_busy",       32'(busy),  32'd0);
        check("rst_commit",     32'(commit), 32'd0);
        rst = 1'b0;
        tick();
        mode = `MODELRN;
        wait_avg(0);
        check("t1_cur_record", cur_record, 32'd0);

        // 2: user 1, three commits
        user = 2'd1;
        wait_avg(0);
        do_commit(0, 90, KEEP);
        check("t2_cur_90", cur_record, 32'd90);
        wait_avg(30);
        do_commit(1, 80, KEEP);
        wait_avg(56);
        do_commit(2, 70, KEEP);
        wait_avg(80);
        check("t2_latency", 32'(done_cyc - start_cyc), 32'(LAT));
        check("t2_cur_70", cur_record, 32'd70);

        // 3: user 2 floor average, then user switch mid-DIV
        user = 2'd2;
        wait_avg(0);
        do_commit(0, 100, KEEP);
        wait_avg(33);
        user = 2'd1;
        for (int i = 0; i < 15; i++) tick();
        check("t3_busy_div", 32'(busy), 32'd1);
        user = 2'd3;
        tick();
        check("t3_abort_valid", 32'(avg_valid), 32'd0);
        check("t3_abort_busy",  32'(busy), 32'd1);
        wait_avg(0);

        // 4: held finished gives one commit; auto mode gives none
        user = 2'd0;
        wait_avg(0);
        c0 = comm_cnt;
        song_num = 2'd0; score = 32'd55; finished = 1'b1;
        exp_nb_q.push_back(KEEP);
        for (int i = 0; i < 20; i++) tick();
        finished = 1'b0;
        tick();
        check("t4_one_commit", 32'(comm_cnt - c0), 32'd1);
        wait_avg(18);
        mode = `MODEAUTO;
        tick();
        c0 = comm_cnt;
        song_num = 2'd1; score = 32'd99; finished = 1'b1;
        tick(); tick();
        finished = 1'b0;
        tick();
        check("t4_auto_no_commit", 32'(comm_cnt - c0), 32'd0);
        check("t4_auto_record", cur_record, 32'd0);
        check("t4_auto_valid", 32'(avg_valid), 32'd1);
        mode = `MODELRN;
        wait_avg(18);

        // 5: keep-best behaviour on user 3 song 0
        user = 2'd3;
        wait_avg(0);
        do_commit(0, 50, KEEP);
        wait_avg(16);
        check("t5_cur_50", cur_record, 32'd50);
        do_commit(0, 40, 1'b0);
        if (KEEP) begin
            for (int i = 0; i < 5; i++) tick();
            check("t5_keep_valid", 32'(avg_valid), 32'd1);
            check("t5_keep_busy",  32'(busy), 32'd0);
            check("t5_keep_cur",   cur_record, 32'd50);
        end else begin
            wait_avg(13);
            check("t5_over_cur", cur_record, 32'd40);
        end
        do_commit(0, 60, KEEP);
        wait_avg(20);
        check("t5_cur_60", cur_record, 32'd60);

        // 6: reset mid-SUM
        song_num = 2'd1; score = 32'd70; finished = 1'b1;
        exp_nb_q.push_back(KEEP);
        tick();
        finished = 1'b0;
        tick();
        check("t6_busy_sum", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy",  32'(busy), 32'd0);
        check("t6_rst_cur",   cur_record, 32'd0);
        check("t6_rst_avg",   user_avg, 32'd0);
        check("t6_rst_valid", 32'(avg_valid), 32'd1);
        check("t6_rst_commit", 32'(commit), 32'd0);
        tick();
        rst = 1'b0;
        wait_avg(0);
        check("t6_rec_cleared", cur_record, 32'd0);
        song_num = 2'd0;
        tick(); tick();
        check("t6_rec0_cleared", cur_record, 32'd0);

        tick();
        check("avg_queue_empty", 32'(exp_avg_q.size()), 32'd0);
        check("nb_queue_empty",  32'(exp_nb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
